// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding the IF/ID register: owns the PC and keeps one
// imem request in flight. Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
  localparam int unsigned W = 16,
  parameter logic [W-1:0] RESET_PC  = 16'h0000,
  parameter logic [W-1:0] NOP_INSTR = 16'hF000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [W-1:0] redirect_pc,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_rvalid,
  input  logic [W-1:0] imem_rdata,
  output logic [W-1:0] toPC,
  output logic [W-1:0] toPCInc,
  output logic [W-1:0] toIR,
  output logic         toValid
`ifdef FETCH_PERF_EN
  ,
  output logic [W-1:0] perf_fetched,
  output logic [W-1:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t       state, stateNext;
  logic [W-1:0] pc, pcNext;
  logic [W-1:0] irQ;
  logic         outValid, outValidNext;
  logic         capture;
  logic         issue;
  logic         consume;

  assign consume = outValid && !stall;
  assign toIR    = outValid ? irQ : NOP_INSTR;
  assign toValid = outValid;

  // State, PC and delivered-slot registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      outValid <= 1'b0;
      irQ      <= NOP_INSTR;
      toPC     <= '0;
      toPCInc  <= '0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      outValid <= outValidNext;
      if (capture) begin
        irQ     <= imem_rdata;
        toPC    <= pc;
        toPCInc <= W'(pc + 1'b1);
      end
    end
  end

  // Next state, request issue and slot update; redirect outranks everything
  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    outValidNext = outValid && stall;
    capture      = 1'b0;
    issue        = reset && !redirect && (state == S_REQ) && !(outValid && stall);
    imem_req     = issue;
    imem_addr    = pc;

    if (redirect) begin
      pcNext       = redirect_pc;
      outValidNext = 1'b0;
      // A response still owed must be swallowed; once it has arrived there is nothing left to drop
      unique case (state)
        S_WAIT:  stateNext = imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  stateNext = imem_rvalid ? S_REQ : S_DROP;
        default: stateNext = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (issue) stateNext = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            capture      = 1'b1;
            outValidNext = 1'b1;
            pcNext       = W'(pc + 1'b1);
            stateNext    = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) stateNext = S_REQ;
        end
        default: stateNext = S_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating consumption and stall-cycle counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (consume && (perf_fetched != {W{1'b1}}))
        perf_fetched <= W'(perf_fetched + 1'b1);
      if (outValid && stall && (perf_stall != {W{1'b1}}))
        perf_stall <= W'(perf_stall + 1'b1);
    end
  end
`else
  logic unusedConsume;
  assign unusedConsume = consume;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-configurable memory model pushes the
// expected (pc, instruction) per request; deliveries pop and compare. FETCH_PERF_EN optional.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'hF000;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
  } expEntry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirectPc;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemRvalid;
  logic [15:0] imemRdata;
  logic [15:0] toPC, toPCInc, toIR;
  logic        toValid;
`ifdef FETCH_PERF_EN
  logic [15:0] perfFetched, perfStall;
  logic [15:0] expFetched, expStall;
`endif

  int          nTests = 0;
  int          nFail  = 0;
  expEntry_t   sbQ[$];
  expEntry_t   cur;
  logic [15:0] expAddr;
  logic        prevValid, prevConsumed;
  logic        pend;
  int          rem;
  int          lat;
  logic [15:0] pendAddr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirectPc),
    .imem_req(imemReq), .imem_addr(imemAddr), .imem_rvalid(imemRvalid), .imem_rdata(imemRdata),
    .toPC(toPC), .toPCInc(toPCInc), .toIR(toIR), .toValid(toValid)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perfFetched), .perf_stall(perfStall)
`endif
  );

  task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0001) return 16'h5678;
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  // One clock cycle: drive at negedge, model memory, sample and score 1 time unit later
  task automatic cycle(input logic st, input logic rd, input logic [15:0] rpc);
    expEntry_t e;
    @(negedge clk);
    stall = st; redirect = rd; redirectPc = rpc;
    imemRvalid = 1'b0;
    if (pend) begin
      if (rem <= 1) begin
        imemRvalid = 1'b1;
        imemRdata  = memWord(pendAddr);
        pend       = 1'b0;
      end else rem--;
    end
    #1;
    if (!reset) begin
      checkEq("reqInReset", 16'(imemReq), 16'h0);
      checkEq("validInReset", 16'(toValid), 16'h0);
      return;
    end
`ifdef FETCH_PERF_EN
    checkEq("perfFetched", perfFetched, expFetched);
    checkEq("perfStall", perfStall, expStall);
    if (toValid && !stall && expFetched != 16'hFFFF) expFetched++;
    if (toValid && stall && expStall != 16'hFFFF) expStall++;
`endif
    if (imemReq) begin
      checkEq("imemAddr", imemAddr, expAddr);
      e.pc = expAddr;
      e.ir = memWord(expAddr);
      sbQ.push_back(e);
      expAddr  = 16'(expAddr + 16'd1);
      pend     = 1'b1;
      rem      = lat;
      pendAddr = imemAddr;
    end
    if ((toValid && stall) || redirect) checkEq("noReqBlocked", 16'(imemReq), 16'h0);
    if (toValid) begin
      if (!prevValid || prevConsumed) begin
        if (sbQ.size() == 0) checkEq("sbUnderflow", 16'h1, 16'h0);
        else cur = sbQ.pop_front();
      end
      checkEq("toPC", toPC, cur.pc);
      checkEq("toPCInc", toPCInc, 16'(cur.pc + 16'd1));
      checkEq("toIR", toIR, cur.ir);
    end else begin
      checkEq("nopIR", toIR, NOP);
    end
    prevValid    = toValid;
    prevConsumed = toValid && !stall;
    if (redirect) begin
      sbQ.delete();
      expAddr = rpc;
    end
  endtask

  task automatic runUntilValid(input logic st, input int maxCyc);
    int n = 0;
    do begin
      cycle(st, 1'b0, 16'h0);
      n++;
    end while (!toValid && n < maxCyc);
    if (!toValid) checkEq("timeoutValid", 16'h0, 16'h1);
  endtask

  task automatic runUntilReq(input int maxCyc);
    int n = 0;
    do begin
      cycle(1'b0, 1'b0, 16'h0);
      n++;
    end while (!imemReq && n < maxCyc);
    if (!imemReq) checkEq("timeoutReq", 16'h0, 16'h1);
  endtask

  task automatic clearModel();
    sbQ.delete();
    expAddr      = 16'h0000;
    prevValid    = 1'b0;
    prevConsumed = 1'b0;
`ifdef FETCH_PERF_EN
    expFetched = '0;
    expStall   = '0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = '0;
    imemRvalid = 1'b0; imemRdata = '0;
    pend = 1'b0; rem = 0; pendAddr = '0; lat = 1;
    cur = '0;
    clearModel();

    // Reset held across edges
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkEq("rstValid", 16'(toValid), 16'h0);
    checkEq("rstIR", toIR, NOP);
    checkEq("rstPC", toPC, 16'h0);
    checkEq("rstPCInc", toPCInc, 16'h0);
    checkEq("rstReq", 16'(imemReq), 16'h0);
    @(posedge clk); #2 reset = 1'b1;

    // Zero-wait memory: request every other cycle, two deliveries
    cycle(0, 0, 0); checkEq("firstReq", 16'(imemReq), 16'h1); checkEq("firstAddr", imemAddr, 16'h0);
    cycle(0, 0, 0); checkEq("waitNoReq", 16'(imemReq), 16'h0);
    cycle(0, 0, 0); checkEq("d0IR", toIR, 16'h1234); checkEq("d0Req", 16'(imemReq), 16'h1);
    cycle(0, 0, 0); checkEq("gapReq", 16'(imemReq), 16'h0);
    cycle(0, 0, 0); checkEq("d1PC", toPC, 16'h1); checkEq("d1IR", toIR, 16'h5678);
    checkEq("d1Addr2", imemAddr, 16'h2);

    // Stall holds a delivered instruction and blocks issue
    cycle(0, 1, 16'h0000);
    runUntilValid(1, 20);
    checkEq("stIR", toIR, 16'h1234);
    repeat (2) begin
      cycle(1, 0, 0);
      checkEq("stHoldIR", toIR, 16'h1234);
      checkEq("stHoldPC", toPC, 16'h0);
      checkEq("stNoReq", 16'(imemReq), 16'h0);
    end
    cycle(0, 0, 0); checkEq("stReleaseReq", 16'(imemReq), 16'h1); checkEq("stReleaseAddr", imemAddr, 16'h1);

    // Slow memory, redirect while a request is outstanding
    lat = 3;
    runUntilReq(20);
    cycle(0, 1, 16'h0040);
    runUntilValid(0, 30);
    checkEq("redirPC", toPC, 16'h0040);

    // Wrap-around at the top of the address space
    lat = 1;
    cycle(0, 1, 16'hFFFF);
    runUntilValid(0, 30);
    checkEq("wrapPC", toPC, 16'hFFFF);
    checkEq("wrapPCInc", toPCInc, 16'h0000);
    checkEq("wrapNextReq", 16'(imemReq), 16'h1);
    checkEq("wrapNextAddr", imemAddr, 16'h0000);

    // Redirect beats stall while an instruction is held
    runUntilValid(1, 30);
    cycle(1, 1, 16'h0100);
    cycle(0, 0, 0);
    checkEq("flushValid", 16'(toValid), 16'h0);
    checkEq("flushIR", toIR, NOP);

    // Mixed random traffic
    for (int i = 0; i < 80; i++) begin
      lat = 1 + int'($urandom_range(2));
      cycle(($urandom_range(3) == 0), ($urandom_range(9) == 0), 16'($urandom));
    end

    // Reset mid-flight with a late response still owed
    lat = 3;
    runUntilReq(20);
    @(posedge clk); #2 reset = 1'b0;
    clearModel();
    cycle(0, 0, 0);
    checkEq("midRstIR", toIR, NOP);
    @(posedge clk); #2 reset = 1'b1;
    runUntilValid(0, 30);
    checkEq("postRstPC", toPC, 16'h0000);
    checkEq("postRstIR", toIR, 16'h1234);
    repeat (6) cycle(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
